conv_window_feeder: RTL



---
 rtl/conv_window_feeder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: cuts a raster-order pixel stream into overlapping 5x5 tiles at stride 3
// and hands each one to the conv_rapida core with a one-cycle start pulse.
//
// Ports:
//   clk, reset        - single rising-edge clock, asynchronous active-low reset
//   pix_data/valid    - input pixel stream, raster order; accepted when pix_valid & pix_ready
//   pix_ready         - registered; high only while filling the line buffer
//   inputMAP          - 5x5 window, element 5*r+c = tile-local row r, column c
//   start             - one-cycle pulse; inputMAP/tile_row/tile_col valid from this cycle on
//   data_valid        - core completion flag; only its rising edge while waiting counts
//   tile_row/tile_col - tile indices of the current window
//   frame_done        - one-cycle pulse after the last tile of a frame completes
module conv_window_feeder #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned IMG_W = 11,
  parameter int unsigned IMG_H = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NBITS-1:0]           pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [24:0][NBITS-1:0]     inputMAP,
  output logic                       start,
  input  logic                       data_valid,
  output logic [$clog2(IMG_H)-1:0]   tile_row,
  output logic [$clog2(IMG_W)-1:0]   tile_col,
  output logic                       frame_done
);

  localparam int unsigned TC   = (IMG_W - 5) / 3 + 1;
  localparam int unsigned TR   = (IMG_H - 5) / 3 + 1;
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  typedef enum logic [1:0] {StFill, StIssue, StWait} state_e;

  state_e                  state_q, state_d;
  logic [NBITS-1:0]        line_q [5][IMG_W];
  logic [2:0]              base_q, base_d;      // physical row holding logical row 0
  logic [2:0]              loaded_q, loaded_d;  // rows completed in the current fill
  logic                    need5_q, need5_d;    // fill needs 5 rows (frame start) or 3
  logic [ColW-1:0]         wr_col_q, wr_col_d;
  logic [ColW-1:0]         tc_q, tc_d, tile_col_q, tile_col_d;
  logic [RowW-1:0]         tr_q, tr_d, tile_row_q, tile_row_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    start_q, start_d;
  logic                    frame_done_q, frame_done_d;
  logic                    dv_prev_q;
  logic [24:0][NBITS-1:0]  map_q, map_d, win;
  logic                    accept, completion;
  logic [2:0]              wr_row;

  function automatic logic [2:0] wrap5(input logic [3:0] x);
    return (x >= 4'd5) ? 3'(x - 4'd5) : x[2:0];
  endfunction

  assign accept     = (state_q == StFill) && pix_ready_q && pix_valid;
  assign completion = (state_q == StWait) && data_valid && !dv_prev_q;

  // During a refill the oldest rows sit at base, base+1, base+2.
  assign wr_row = wrap5({1'b0, base_q} + {1'b0, loaded_q});

  always_ff @(posedge clk) begin
    if (accept) begin
      line_q[wr_row][wr_col_q] <= pix_data;
    end
  end

  // Window gather: logical row r lives at physical row (base + r) mod 5, columns from 3*tc.
  for (genvar r = 0; r < 5; r++) begin : g_row
    logic [2:0] phys_row;
    assign phys_row = wrap5({1'b0, base_q} + 4'(r));
    for (genvar c = 0; c < 5; c++) begin : g_col
      logic [ColW-1:0] col;
      assign col         = tc_q + tc_q + tc_q + ColW'(c);
      assign win[5*r+c]  = line_q[phys_row][col];
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    loaded_d     = loaded_q;
    need5_d      = need5_q;
    wr_col_d     = wr_col_q;
    tc_d         = tc_q;
    tr_d         = tr_q;
    tile_col_d   = tile_col_q;
    tile_row_d   = tile_row_q;
    map_d        = map_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      StFill: begin
        if (accept) begin
          if (wr_col_q == ColW'(IMG_W - 1)) begin
            wr_col_d = '0;
            if (loaded_q == (need5_q ? 3'd4 : 3'd2)) begin
              loaded_d = '0;
              state_d  = StIssue;
              if (!need5_q) begin
                base_d = wrap5({1'b0, base_q} + 4'd3);
              end
            end else begin
              loaded_d = loaded_q + 3'd1;
            end
          end else begin
            wr_col_d = wr_col_q + ColW'(1);
          end
        end
      end
      StIssue: begin
        map_d      = win;
        start_d    = 1'b1;
        tile_row_d = tr_q;
        tile_col_d = tc_q;
        state_d    = StWait;
      end
      StWait: begin
        if (completion) begin
          if (tc_q != ColW'(TC - 1)) begin
            tc_d    = tc_q + ColW'(1);
            state_d = StIssue;
          end else if (tr_q != RowW'(TR - 1)) begin
            tc_d    = '0;
            tr_d    = tr_q + RowW'(1);
            need5_d = 1'b0;
            state_d = StFill;
          end else begin
            tc_d         = '0;
            tr_d         = '0;
            base_d       = '0;
            need5_d      = 1'b1;
            frame_done_d = 1'b1;
            state_d      = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
    pix_ready_d = (state_d == StFill);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      base_q       <= '0;
      loaded_q     <= '0;
      need5_q      <= 1'b1;
      wr_col_q     <= '0;
      tc_q         <= '0;
      tr_q         <= '0;
      tile_col_q   <= '0;
      tile_row_q   <= '0;
      map_q        <= '0;
      pix_ready_q  <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      dv_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      loaded_q     <= loaded_d;
      need5_q      <= need5_d;
      wr_col_q     <= wr_col_d;
      tc_q         <= tc_d;
      tr_q         <= tr_d;
      tile_col_q   <= tile_col_d;
      tile_row_q   <= tile_row_d;
      map_q        <= map_d;
      pix_ready_q  <= pix_ready_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      dv_prev_q    <= data_valid;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign inputMAP   = map_q;
  assign start      = start_q;
  assign tile_row   = tile_row_q;
  assign tile_col   = tile_col_q;
  assign frame_done = frame_done_q;

endmodule
